// File: rtl/program_sequencer_stack_pkg.sv
// Shared types for the program sequencer: next-address select codes and
// page-target construction used by jmp/jsr.
package program_sequencer_pkg;

  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_RTS,
    SEL_JSR,
    SEL_JMP,
    SEL_JNZ,
    SEL_INC
  } sel_e;

  // Places a page number in the top bits of an address, low bits zero.
  function automatic logic [31:0] page_target(input logic [31:0] page,
                                              input int addr_w,
                                              input int page_w);
    return page << (addr_w - page_w);
  endfunction

endpackage

// File: rtl/program_sequencer_stack_if.sv
// Decoder-to-sequencer bundle: control requests in, fetch address/pc/stack status out.
interface program_sequencer_stack_if #(
  parameter int ADDR_W      = 8,
  parameter int JMP_W       = 4,
  parameter int JSR_W       = 5,
  parameter int STACK_DEPTH = 4
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic              hold;
  logic              jmp;
  logic              jmp_nz;
  logic              dont_jmp;
  logic              jsr;
  logic              rts;
  logic              clr_flags;
  logic [JMP_W-1:0]  jmp_addr;
  logic [JSR_W-1:0]  jsr_addr;
  logic [ADDR_W-1:0] pm_addr;
  logic [ADDR_W-1:0] pc;
  logic [LVL_W-1:0]  stack_level;
  logic              stack_overflow;
  logic              stack_underflow;

  modport master (
    output hold, jmp, jmp_nz, dont_jmp, jsr, rts, clr_flags, jmp_addr, jsr_addr,
    input  pm_addr, pc, stack_level, stack_overflow, stack_underflow
  );

  modport slave (
    input  hold, jmp, jmp_nz, dont_jmp, jsr, rts, clr_flags, jmp_addr, jsr_addr,
    output pm_addr, pc, stack_level, stack_overflow, stack_underflow
  );

endinterface

// File: rtl/program_sequencer_stack_return_stack.sv
// LIFO return-address stack; top is combinational, push/pop take effect on the next edge.
// Push when full and pop when empty are ignored; the level never wraps.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] top,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LVL_W-1:0] rd_lvl;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // Pop wins if both are requested, so a simultaneous push is dropped.
  assign do_push = push & ~full & ~pop;
  assign rd_lvl  = level - LVL_W'(1);
  assign top     = empty ? '0 : mem[rd_lvl[IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (do_pop) begin
      level <= level - LVL_W'(1);
    end else if (do_push) begin
      level <= level + LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[level[IDX_W-1:0]] <= data_in;
    end
  end

endmodule

// File: rtl/program_sequencer_stack.sv
// Program sequencer with return stack: pm_addr is combinational from controls/pc,
// pc/stack/flags update on the next edge; hold stalls the fetch with no state change.
module program_sequencer_stack
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int JMP_W       = 4,
  parameter int JSR_W       = 5,
  parameter int STACK_DEPTH = 4
) (
  input logic                       clk,
  input logic                       async_reset_n,
  program_sequencer_stack_if.slave  sq
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  sel_e              sel;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] nxt_addr;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] jsr_tgt;
  logic [ADDR_W-1:0] tos;
  logic [LVL_W-1:0]  level;
  logic              full;
  logic              empty;
  logic              ovf_q;
  logic              unf_q;
  logic              ovf_set;
  logic              unf_set;

  assign pc_inc  = pc_q + ADDR_W'(1);
  assign jmp_tgt = ADDR_W'(page_target(32'(sq.jmp_addr), ADDR_W, JMP_W));
  assign jsr_tgt = ADDR_W'(page_target(32'(sq.jsr_addr), ADDR_W, JSR_W));

  always_comb begin
    sel = SEL_INC;
    if (sq.hold)                       sel = SEL_HOLD;
    else if (sq.rts)                   sel = SEL_RTS;
    else if (sq.jsr)                   sel = SEL_JSR;
    else if (sq.jmp)                   sel = SEL_JMP;
    else if (sq.jmp_nz && !sq.dont_jmp) sel = SEL_JNZ;
  end

  always_comb begin
    nxt_addr = pc_inc;
    case (sel)
      SEL_HOLD: nxt_addr = pc_q;
      SEL_RTS:  nxt_addr = empty ? pc_inc : tos;
      SEL_JSR:  nxt_addr = jsr_tgt;
      SEL_JMP,
      SEL_JNZ:  nxt_addr = jmp_tgt;
      default:  nxt_addr = pc_inc;
    endcase
  end

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk     (clk),
    .rst_n   (async_reset_n),
    .push    (sel == SEL_JSR),
    .pop     (sel == SEL_RTS),
    .data_in (pc_inc),
    .top     (tos),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  assign ovf_set = (sel == SEL_JSR) && full;
  assign unf_set = (sel == SEL_RTS) && empty;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q <= nxt_addr;
      // A new error in the same cycle as a clear must stay visible.
      if (ovf_set)           ovf_q <= 1'b1;
      else if (sq.clr_flags) ovf_q <= 1'b0;
      if (unf_set)           unf_q <= 1'b1;
      else if (sq.clr_flags) unf_q <= 1'b0;
    end
  end

  assign sq.pm_addr         = async_reset_n ? nxt_addr : '0;
  assign sq.pc              = pc_q;
  assign sq.stack_level     = level;
  assign sq.stack_overflow  = ovf_q;
  assign sq.stack_underflow = unf_q;

endmodule

// File: tb/tb_program_sequencer_stack.sv
// Directed bench for program_sequencer_stack: reset, increment/wrap, jsr/rts nesting,
// overflow/underflow flags, hold priority, conditional jump and async reset mid-subroutine.
module tb_program_sequencer_stack;

  logic clk = 1'b0;
  logic async_reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  program_sequencer_stack_if #(.ADDR_W(8), .JMP_W(4), .JSR_W(5), .STACK_DEPTH(4)) bus ();

  program_sequencer_stack #(.ADDR_W(8), .JMP_W(4), .JSR_W(5), .STACK_DEPTH(4)) dut (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .sq            (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.hold = 0; bus.jmp = 0; bus.jmp_nz = 0; bus.dont_jmp = 0;
    bus.jsr = 0; bus.rts = 0; bus.clr_flags = 0;
    bus.jmp_addr = '0; bus.jsr_addr = '0;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    async_reset_n = 1'b0;
    idle();
    #12;
    n_checks++; if (bus.pm_addr !== 8'h00) begin n_fail++; $display("FAIL reset_pm_addr got %h exp 00", bus.pm_addr); end
    n_checks++; if (bus.pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc got %h exp 00", bus.pc); end
    n_checks++; if (bus.stack_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", bus.stack_level); end
    n_checks++; if ({bus.stack_overflow, bus.stack_underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b exp 00", {bus.stack_overflow, bus.stack_underflow}); end
    @(negedge clk);
    async_reset_n = 1'b1;
    #1;
    n_checks++; if (bus.pc !== 8'h00) begin n_fail++; $display("FAIL release_pc got %h exp 00", bus.pc); end
  endtask

  task automatic test_free_run();
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++; if (bus.pc !== 8'(i)) begin n_fail++; $display("FAIL free_run_pc got %h exp %h", bus.pc, 8'(i)); end
    end
  endtask

  task automatic test_wrap();
    bus.jmp = 1; bus.jmp_addr = 4'hF;
    #1;
    n_checks++; if (bus.pm_addr !== 8'hF0) begin n_fail++; $display("FAIL jmp_pm_addr got %h exp f0", bus.pm_addr); end
    tick();
    idle();
    repeat (15) tick();
    n_checks++; if (bus.pc !== 8'hFF) begin n_fail++; $display("FAIL pre_wrap_pc got %h exp ff", bus.pc); end
    n_checks++; if (bus.pm_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_pm_addr got %h exp 00", bus.pm_addr); end
    tick();
    n_checks++; if (bus.pc !== 8'h00) begin n_fail++; $display("FAIL wrap_pc got %h exp 00", bus.pc); end
  endtask

  task automatic test_jsr_rts();
    bus.jmp = 1; bus.jmp_addr = 4'h1;
    tick();
    idle();
    tick(); tick();
    n_checks++; if (bus.pc !== 8'h12) begin n_fail++; $display("FAIL setup_pc got %h exp 12", bus.pc); end
    bus.jsr = 1; bus.jsr_addr = 5'h03;
    #1;
    n_checks++; if (bus.pm_addr !== 8'h18) begin n_fail++; $display("FAIL jsr_pm_addr got %h exp 18", bus.pm_addr); end
    tick();
    idle();
    n_checks++; if (bus.stack_level !== 3'd1) begin n_fail++; $display("FAIL jsr_level got %0d exp 1", bus.stack_level); end
    tick();
    bus.rts = 1;
    #1;
    n_checks++; if (bus.pm_addr !== 8'h13) begin n_fail++; $display("FAIL rts_pm_addr got %h exp 13", bus.pm_addr); end
    tick();
    idle();
    n_checks++; if (bus.stack_level !== 3'd0) begin n_fail++; $display("FAIL rts_level got %0d exp 0", bus.stack_level); end
    n_checks++; if (bus.pc !== 8'h13) begin n_fail++; $display("FAIL rts_pc got %h exp 13", bus.pc); end
  endtask

  task automatic test_overflow();
    logic [7:0] ret [4];
    ret[0] = 8'h14; ret[1] = 8'h09; ret[2] = 8'h11; ret[3] = 8'h19;
    for (int i = 1; i <= 4; i++) begin
      bus.jsr = 1; bus.jsr_addr = 5'(i);
      tick();
    end
    n_checks++; if (bus.stack_level !== 3'd4) begin n_fail++; $display("FAIL nest_level got %0d exp 4", bus.stack_level); end
    n_checks++; if (bus.stack_overflow !== 1'b0) begin n_fail++; $display("FAIL nest_ovf got %b exp 0", bus.stack_overflow); end
    bus.jsr_addr = 5'd5;
    #1;
    n_checks++; if (bus.pm_addr !== 8'h28) begin n_fail++; $display("FAIL ovf_pm_addr got %h exp 28", bus.pm_addr); end
    tick();
    idle();
    n_checks++; if (bus.stack_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level got %0d exp 4", bus.stack_level); end
    n_checks++; if (bus.stack_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", bus.stack_overflow); end
    n_checks++; if (bus.pc !== 8'h28) begin n_fail++; $display("FAIL ovf_pc got %h exp 28", bus.pc); end
    for (int k = 3; k >= 0; k--) begin
      bus.rts = 1;
      #1;
      n_checks++; if (bus.pm_addr !== ret[k]) begin n_fail++; $display("FAIL unwind_pm_addr[%0d] got %h exp %h", k, bus.pm_addr, ret[k]); end
      tick();
      n_checks++; if (bus.stack_level !== 3'(k)) begin n_fail++; $display("FAIL unwind_level[%0d] got %0d exp %0d", k, bus.stack_level, k); end
    end
    idle();
    n_checks++; if (bus.stack_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", bus.stack_overflow); end
    bus.clr_flags = 1;
    tick();
    idle();
    n_checks++; if (bus.stack_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", bus.stack_overflow); end
  endtask

  task automatic test_underflow();
    bus.jmp = 1; bus.jmp_addr = 4'h4;
    tick();
    bus.jmp = 0; bus.rts = 1;
    #1;
    n_checks++; if (bus.pm_addr !== 8'h41) begin n_fail++; $display("FAIL unf_pm_addr got %h exp 41", bus.pm_addr); end
    tick();
    n_checks++; if (bus.stack_underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag got %b exp 1", bus.stack_underflow); end
    n_checks++; if (bus.stack_level !== 3'd0) begin n_fail++; $display("FAIL unf_level got %0d exp 0", bus.stack_level); end
    bus.clr_flags = 1;
    tick();
    n_checks++; if (bus.stack_underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set_beats_clr got %b exp 1", bus.stack_underflow); end
    bus.rts = 0;
    tick();
    idle();
    n_checks++; if (bus.stack_underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b exp 0", bus.stack_underflow); end
  endtask

  task automatic test_hold_jnz();
    logic [7:0] p;
    p = bus.pc;
    bus.hold = 1; bus.jsr = 1; bus.jsr_addr = 5'h1F;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.pm_addr !== p) begin n_fail++; $display("FAIL hold_pm_addr[%0d] got %h exp %h", i, bus.pm_addr, p); end
      tick();
    end
    idle();
    n_checks++; if (bus.pc !== p) begin n_fail++; $display("FAIL hold_pc got %h exp %h", bus.pc, p); end
    n_checks++; if (bus.stack_level !== 3'd0) begin n_fail++; $display("FAIL hold_level got %0d exp 0", bus.stack_level); end
    bus.jmp_nz = 1; bus.dont_jmp = 1; bus.jmp_addr = 4'hA;
    #1;
    n_checks++; if (bus.pm_addr !== 8'(p + 8'd1)) begin n_fail++; $display("FAIL jnz_not_taken got %h exp %h", bus.pm_addr, 8'(p + 8'd1)); end
    bus.dont_jmp = 0;
    #1;
    n_checks++; if (bus.pm_addr !== 8'hA0) begin n_fail++; $display("FAIL jnz_taken got %h exp a0", bus.pm_addr); end
    tick();
    idle();
  endtask

  task automatic test_async_reset();
    bus.rts = 1;
    tick();
    bus.rts = 0;
    for (int i = 0; i < 3; i++) begin
      bus.jsr = 1; bus.jsr_addr = 5'(i + 8);
      tick();
    end
    idle();
    n_checks++; if (bus.stack_level !== 3'd3) begin n_fail++; $display("FAIL pre_reset_level got %0d exp 3", bus.stack_level); end
    n_checks++; if (bus.stack_underflow !== 1'b1) begin n_fail++; $display("FAIL pre_reset_unf got %b exp 1", bus.stack_underflow); end
    #2;
    async_reset_n = 1'b0;
    #1;
    n_checks++; if (bus.pc !== 8'h00) begin n_fail++; $display("FAIL async_pc got %h exp 00", bus.pc); end
    n_checks++; if (bus.stack_level !== 3'd0) begin n_fail++; $display("FAIL async_level got %0d exp 0", bus.stack_level); end
    n_checks++; if (bus.stack_underflow !== 1'b0) begin n_fail++; $display("FAIL async_unf got %b exp 0", bus.stack_underflow); end
    n_checks++; if (bus.pm_addr !== 8'h00) begin n_fail++; $display("FAIL async_pm_addr got %h exp 00", bus.pm_addr); end
    @(negedge clk);
    async_reset_n = 1'b1;
    tick();
    n_checks++; if (bus.pc !== 8'h01) begin n_fail++; $display("FAIL post_reset_pc got %h exp 01", bus.pc); end
    bus.rts = 1;
    #1;
    n_checks++; if (bus.pm_addr !== 8'h02) begin n_fail++; $display("FAIL post_reset_rts got %h exp 02", bus.pm_addr); end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_wrap();
    test_jsr_rts();
    test_overflow();
    test_underflow();
    test_hold_jnz();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
